// File: rtl/ps2_mouse_ctrl.sv
// ps2_mouse_ctrl
//   Brings up a PS/2 mouse through the rx/tx transceiver, then decodes
//   3-byte stream-mode movement packets.
//   Init: send 0xFF, expect 0xFA/0xAA/0x00; send 0xF4, expect 0xFA.
//   Each init fault (bad byte or timeout) retries up to MAX_RETRY times,
//   then the block parks in FAIL until ReInit or Reset.
//
// Ports:
//   Clk, Reset (sync, active-high), ReInit (restart init sequence)
//   Write/TxData             : command strobe and byte to the transceiver
//   RxData/RxDone, TxDone    : transceiver receive byte/strobe, send-complete strobe
//   Ready / Error            : in stream states / in FAIL
//   PacketValid              : 1-cycle strobe, new Buttons/DX/DY/Ovf
//   Buttons {M,R,L}, DX/DY 9-bit signed deltas, Ovf {Y,X}
module ps2_mouse_ctrl #(
    parameter int TIMEOUT   = 25000000,
    parameter int TW        = 25,
    parameter int MAX_RETRY = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ReInit,
    output logic       Write,
    output logic [7:0] TxData,
    input  logic [7:0] RxData,
    input  logic       RxDone,
    input  logic       TxDone,
    output logic       Ready,
    output logic       Error,
    output logic       PacketValid,
    output logic [2:0] Buttons,
    output logic [8:0] DX,
    output logic [8:0] DY,
    output logic [1:0] Ovf
);

    localparam int            RW          = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] TIMEOUT_V   = TW'(TIMEOUT);
    localparam logic [RW-1:0] MAX_RETRY_V = RW'(MAX_RETRY);

    typedef enum logic [3:0] {
        RST_SEND, RST_TX, RST_ACK, RST_BAT, RST_ID,
        EN_SEND, EN_TX, EN_ACK,
        S_B0, S_B1, S_B2,
        FAIL
    } state_t;

    state_t        state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [RW-1:0] retry, retry_d;
    // First packet byte without its always-1 sync bit: {b0[7:4], b0[2:0]}
    logic [6:0]    b0, b0_d;
    logic [7:0]    b1, b1_d;

    logic          write_d, pv_d;
    logic [7:0]    tx_data_d;
    logic [2:0]    buttons_d;
    logic [8:0]    dx_d, dy_d;
    logic [1:0]    ovf_d;
    logic          timer_run, timed_out, init_fault;

    always_comb begin
        timer_run  = !(state inside {S_B0, FAIL, RST_SEND, EN_SEND});
        timed_out  = timer_run && (timer >= TIMEOUT_V);

        state_d    = state;
        retry_d    = retry;
        b0_d       = b0;
        b1_d       = b1;
        write_d    = 1'b0;
        tx_data_d  = TxData;
        pv_d       = 1'b0;
        buttons_d  = Buttons;
        dx_d       = DX;
        dy_d       = DY;
        ovf_d      = Ovf;
        init_fault = 1'b0;

        case (state)
            RST_SEND: begin
                write_d   = 1'b1;
                tx_data_d = 8'hFF;
                state_d   = RST_TX;
            end
            RST_TX: begin
                if (TxDone)         state_d    = RST_ACK;
                else if (timed_out) init_fault = 1'b1;
            end
            RST_ACK: begin
                if (RxDone) begin
                    if (RxData == 8'hFA) state_d    = RST_BAT;
                    else                 init_fault = 1'b1;
                end else if (timed_out) init_fault = 1'b1;
            end
            RST_BAT: begin
                if (RxDone) begin
                    if (RxData == 8'hAA) state_d    = RST_ID;
                    else                 init_fault = 1'b1;
                end else if (timed_out) init_fault = 1'b1;
            end
            RST_ID: begin
                if (RxDone) begin
                    if (RxData == 8'h00) state_d    = EN_SEND;
                    else                 init_fault = 1'b1;
                end else if (timed_out) init_fault = 1'b1;
            end
            EN_SEND: begin
                write_d   = 1'b1;
                tx_data_d = 8'hF4;
                state_d   = EN_TX;
            end
            EN_TX: begin
                if (TxDone)         state_d    = EN_ACK;
                else if (timed_out) init_fault = 1'b1;
            end
            EN_ACK: begin
                if (RxDone) begin
                    if (RxData == 8'hFA) state_d    = S_B0;
                    else                 init_fault = 1'b1;
                end else if (timed_out) init_fault = 1'b1;
            end
            // Bytes without the sync bit are dropped so the stream can realign.
            S_B0: begin
                if (RxDone && RxData[3]) begin
                    b0_d    = {RxData[7:4], RxData[2:0]};
                    state_d = S_B1;
                end
            end
            S_B1: begin
                if (RxDone) begin
                    b1_d    = RxData;
                    state_d = S_B2;
                end else if (timed_out) state_d = S_B0;
            end
            S_B2: begin
                if (RxDone) begin
                    buttons_d = b0[2:0];
                    dx_d      = {b0[3], b1};
                    dy_d      = {b0[4], RxData};
                    ovf_d     = {b0[6], b0[5]};
                    pv_d      = 1'b1;
                    state_d   = S_B0;
                end else if (timed_out) state_d = S_B0;
            end
            FAIL:    state_d = FAIL;
            default: state_d = RST_SEND;
        endcase

        if (init_fault) begin
            if (retry < MAX_RETRY_V) begin
                retry_d = retry + 1'b1;
                state_d = RST_SEND;
            end else begin
                state_d = FAIL;
            end
        end

        // ReInit wins over any strobe in the same cycle, including a packet
        // completion; visible data outputs keep their last values.
        if (ReInit) begin
            state_d   = RST_SEND;
            retry_d   = '0;
            write_d   = 1'b0;
            tx_data_d = TxData;
            pv_d      = 1'b0;
            buttons_d = Buttons;
            dx_d      = DX;
            dy_d      = DY;
            ovf_d     = Ovf;
        end

        if (state_d != state) timer_d = '0;
        else if (timer_run)   timer_d = timer + 1'b1;
        else                  timer_d = timer;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= RST_SEND;
            timer       <= '0;
            retry       <= '0;
            b0          <= '0;
            b1          <= '0;
            Write       <= 1'b0;
            TxData      <= '0;
            Ready       <= 1'b0;
            Error       <= 1'b0;
            PacketValid <= 1'b0;
            Buttons     <= '0;
            DX          <= '0;
            DY          <= '0;
            Ovf         <= '0;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            retry       <= retry_d;
            b0          <= b0_d;
            b1          <= b1_d;
            Write       <= write_d;
            TxData      <= tx_data_d;
            Ready       <= state_d inside {S_B0, S_B1, S_B2};
            Error       <= (state_d == FAIL);
            PacketValid <= pv_d;
            Buttons     <= buttons_d;
            DX          <= dx_d;
            DY          <= dy_d;
            Ovf         <= ovf_d;
        end
    end

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// tb_ps2_mouse_ctrl
//   Directed bench for ps2_mouse_ctrl. Expected command bytes and packets are
//   queued as stimulus is issued; a monitor pops and compares them whenever
//   the DUT strobes Write or PacketValid.
module tb_ps2_mouse_ctrl;

    localparam int TIMEOUT   = 100;
    localparam int TW        = 8;
    localparam int MAX_RETRY = 3;

    logic       Clk    = 1'b0;
    logic       Reset  = 1'b1;
    logic       ReInit = 1'b0;
    logic [7:0] RxData = 8'h00;
    logic       RxDone = 1'b0;
    logic       TxDone = 1'b0;
    logic       Write;
    logic [7:0] TxData;
    logic       Ready;
    logic       Error;
    logic       PacketValid;
    logic [2:0] Buttons;
    logic [8:0] DX;
    logic [8:0] DY;
    logic [1:0] Ovf;

    ps2_mouse_ctrl #(
        .TIMEOUT  (TIMEOUT),
        .TW       (TW),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .ReInit     (ReInit),
        .Write      (Write),
        .TxData     (TxData),
        .RxData     (RxData),
        .RxDone     (RxDone),
        .TxDone     (TxDone),
        .Ready      (Ready),
        .Error      (Error),
        .PacketValid(PacketValid),
        .Buttons    (Buttons),
        .DX         (DX),
        .DY         (DY),
        .Ovf        (Ovf)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int fails    = 0;
    int n_writes = 0;
    int n_pkts   = 0;
    int cyc      = 0;

    logic [7:0]  exp_tx[$];
    logic [22:0] exp_pkt[$];   // {Ovf, Buttons, DX, DY}

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge Clk) begin
        #1;
        cyc++;
        if (!Reset) begin
            if (Write === 1'b1) begin
                n_writes++;
                if (exp_tx.size() > 0) chk("tx_data", 32'(TxData), 32'(exp_tx.pop_front()));
                else                   chk("write_unexpected", 32'(Write), 32'h0);
            end
            if (PacketValid === 1'b1) begin
                n_pkts++;
                if (exp_pkt.size() > 0)
                    chk("packet", 32'({Ovf, Buttons, DX, DY}), 32'(exp_pkt.pop_front()));
                else
                    chk("packet_unexpected", 32'(PacketValid), 32'h0);
            end
            chk("ready_error_exclusive", 32'(Ready & Error), 32'h0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic rx(input logic [7:0] b);
        @(negedge Clk);
        RxData = b;
        RxDone = 1'b1;
        @(negedge Clk);
        RxDone = 1'b0;
    endtask

    task automatic txd();
        @(negedge Clk);
        TxDone = 1'b1;
        @(negedge Clk);
        TxDone = 1'b0;
    endtask

    task automatic wait_writes(input int target, input int bound, input string tag);
        int k = 0;
        while (n_writes < target && k < bound) begin
            @(negedge Clk);
            k++;
        end
        chk(tag, 32'(n_writes >= target), 32'h1);
    endtask

    task automatic wait_pkts(input int target, input int bound, input string tag);
        int k = 0;
        while (n_pkts < target && k < bound) begin
            @(negedge Clk);
            k++;
        end
        chk(tag, 32'(n_pkts >= target), 32'h1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int gap;

        // Reset state
        tick(3);
        chk("rst_write",   32'(Write),       32'h0);
        chk("rst_txdata",  32'(TxData),      32'h0);
        chk("rst_ready",   32'(Ready),       32'h0);
        chk("rst_error",   32'(Error),       32'h0);
        chk("rst_pv",      32'(PacketValid), 32'h0);
        chk("rst_buttons", 32'(Buttons),     32'h0);
        chk("rst_dx",      32'(DX),          32'h0);
        chk("rst_dy",      32'(DY),          32'h0);
        chk("rst_ovf",     32'(Ovf),         32'h0);

        // Normal bring-up
        exp_tx.push_back(8'hFF);
        Reset = 1'b0;
        wait_writes(1, 5, "init_reset_write");
        txd();
        rx(8'hFA);
        rx(8'hAA);
        exp_tx.push_back(8'hF4);
        rx(8'h00);
        wait_writes(2, 5, "init_enable_write");
        txd();
        rx(8'hFA);
        tick(2);
        chk("init_ready", 32'(Ready), 32'h1);
        chk("init_error", 32'(Error), 32'h0);

        // Basic packet
        exp_pkt.push_back({2'b00, 3'b001, 9'h005, 9'h1FE});
        rx(8'h29); rx(8'h05); rx(8'hFE);
        wait_pkts(1, 5, "pkt1_seen");

        // Resync: 0x01 lacks the sync bit and is dropped
        exp_pkt.push_back({2'b00, 3'b000, 9'h180, 9'h110});
        rx(8'h01); rx(8'h38); rx(8'h80); rx(8'h10);
        wait_pkts(2, 5, "pkt2_seen");

        // Overflow bits and all buttons
        exp_pkt.push_back({2'b11, 3'b111, 9'h07F, 9'h080});
        rx(8'hCF); rx(8'h7F); rx(8'h80);
        wait_pkts(3, 5, "pkt3_seen");
        tick(5);
        chk("dx_hold",     32'(DX),     32'h07F);
        chk("txdata_hold", 32'(TxData), 32'hF4);

        // Stream timeout discards a partial packet
        exp_pkt.push_back({2'b00, 3'b000, 9'h001, 9'h001});
        rx(8'h08);
        tick(110);
        chk("stream_to_ready", 32'(Ready), 32'h1);
        chk("stream_to_error", 32'(Error), 32'h0);
        rx(8'h08); rx(8'h01); rx(8'h01);
        wait_pkts(4, 5, "pkt4_seen");

        // ReInit coincident with the last byte of a packet
        rx(8'h08); rx(8'h02);
        @(negedge Clk);
        RxData = 8'h03;
        RxDone = 1'b1;
        ReInit = 1'b1;
        exp_tx.push_back(8'hFF);
        @(negedge Clk);
        RxDone = 1'b0;
        ReInit = 1'b0;
        chk("reinit_ready", 32'(Ready), 32'h0);
        wait_writes(3, 5, "reinit_write");
        tick(3);
        chk("reinit_no_pkt", 32'(n_pkts), 32'd4);

        // Bad ACK on every attempt: retries exhaust, then FAIL
        for (int i = 0; i < 4; i++) begin
            txd();
            if (i < 3) exp_tx.push_back(8'hFF);
            rx(8'hFE);
            if (i < 3) wait_writes(4 + i, 5, "retry_write");
        end
        tick(2);
        chk("fail_error", 32'(Error), 32'h1);
        chk("fail_ready", 32'(Ready), 32'h0);
        tick(150);
        chk("fail_hold_error", 32'(Error),    32'h1);
        chk("fail_no_write",   32'(n_writes), 32'd6);

        // ReInit out of FAIL
        exp_tx.push_back(8'hFF);
        @(negedge Clk);
        ReInit = 1'b1;
        @(negedge Clk);
        ReInit = 1'b0;
        chk("reinit_clr_error", 32'(Error), 32'h0);
        chk("reinit_write_lat", 32'(Write), 32'h0);
        wait_writes(7, 3, "fail_reinit_write");

        // Missing TxDone: resend after TIMEOUT cycles
        exp_tx.push_back(8'hFF);
        start = cyc;
        wait_writes(8, 120, "tx_timeout_write");
        gap = cyc - start;
        chk("tx_timeout_gap", 32'((gap >= 101) && (gap <= 104)), 32'h1);

        // Complete bring-up again and take one more packet
        txd();
        rx(8'hFA);
        rx(8'hAA);
        exp_tx.push_back(8'hF4);
        rx(8'h00);
        wait_writes(9, 5, "reinit_enable_write");
        txd();
        rx(8'hFA);
        tick(2);
        chk("reinit_ready_up", 32'(Ready), 32'h1);
        exp_pkt.push_back({2'b00, 3'b100, 9'h1FF, 9'h000});
        rx(8'h1C); rx(8'hFF); rx(8'h00);
        wait_pkts(5, 5, "pkt5_seen");

        tick(5);
        chk("tx_queue_empty",  32'(exp_tx.size()),  32'h0);
        chk("pkt_queue_empty", 32'(exp_pkt.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
